// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered status flags
// and an optional first-word-fall-through output register.
module sync_fifo #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 9,
  parameter int AF_OFFSET = 4,
  parameter int AE_OFFSET = 4,
  parameter int FWFT      = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              we,
  input  logic              re,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              wr_err,
  output logic              rd_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit LP_FWFT = (FWFT != 0);

  localparam logic [ADDR_W:0] LP_FULL =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_AF =
    (ADDR_W+1)'(DEPTH - AF_OFFSET);
  localparam logic [ADDR_W:0] LP_AE =
    (ADDR_W+1)'(AE_OFFSET);
  localparam logic [ADDR_W:0] LP_C1 =
    (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LP_P1 =
    ADDR_W'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_cnt;
  logic [DATA_W-1:0] r_dout;
  logic              r_empty;
  logic              r_full;
  logic              r_ae;
  logic              r_af;
  logic              r_werr;
  logic              r_rerr;

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_ram_empty;
  logic              w_byp;
  logic              w_ram_we;
  logic              w_rptr_inc;
  logic [ADDR_W:0]   w_cnt_nx;
  logic [DATA_W-1:0] w_ram_q;

  assign w_wr_acc    = we & ~r_full;
  assign w_rd_acc    = re & ~r_empty;
  assign w_ram_empty = (r_rptr == r_wptr);
  assign w_ram_q     = r_mem[r_rptr];

  // In FWFT mode the RAM excludes the head word, so it never
  // fills and pointer equality alone means it is empty.
  assign w_byp = LP_FWFT &
    (r_empty | (w_rd_acc & w_ram_empty));
  assign w_ram_we   = w_wr_acc & ~w_byp;
  assign w_rptr_inc = w_rd_acc &
    (~LP_FWFT | ~w_ram_empty);

  always_comb begin
    w_cnt_nx = r_cnt;
    if (w_wr_acc && !w_rd_acc) begin
      w_cnt_nx = r_cnt + LP_C1;
    end else if (!w_wr_acc && w_rd_acc) begin
      w_cnt_nx = r_cnt - LP_C1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_ram_we) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_dout  <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_ae    <= 1'b1;
      r_af    <= 1'b0;
      r_werr  <= 1'b0;
      r_rerr  <= 1'b0;
    end else begin
      if (w_ram_we) begin
        r_wptr <= r_wptr + LP_P1;
      end
      if (w_rptr_inc) begin
        r_rptr <= r_rptr + LP_P1;
      end
      if (w_wr_acc && w_byp) begin
        r_dout <= din;
      end else if (w_rptr_inc) begin
        r_dout <= w_ram_q;
      end
      r_cnt   <= w_cnt_nx;
      r_empty <= (w_cnt_nx == '0);
      r_full  <= (w_cnt_nx == LP_FULL);
      r_ae    <= (w_cnt_nx <= LP_AE);
      r_af    <= (w_cnt_nx >= LP_AF);
      r_werr  <= we & r_full;
      r_rerr  <= re & r_empty;
    end
  end

  assign dout         = r_dout;
  assign empty        = r_empty;
  assign full         = r_full;
  assign almost_empty = r_ae;
  assign almost_full  = r_af;
  assign count        = r_cnt;
  assign wr_err       = r_werr;
  assign rd_err       = r_rerr;

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data width in bits, 1..72.
REQ-002 SHALL have parameter ADDR_W, default 9: log2 of depth, so DEPTH = 2**ADDR_W, range 2..12.
REQ-003 SHALL have parameter AF_OFFSET, default 4: almost_full threshold, 1..DEPTH-1.
REQ-004 SHALL have parameter AE_OFFSET, default 4: almost_empty threshold, 1..DEPTH-1.
REQ-005 SHALL have parameter FWFT, default 0: 0 is standard read mode, 1 is first-word-fall-through.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port din, input, DATA_W bits: write data.
REQ-009 SHALL have port we, input, 1 bit: write request.
REQ-010 SHALL have port re, input, 1 bit: read/pop request.
REQ-011 SHALL have port dout, output, DATA_W bits: read data, registered.
REQ-012 SHALL have ports empty, full, almost_empty and almost_full, each an output, 1 bit, registered status flag.
REQ-013 SHALL have port count, output, ADDR_W+1 bits: occupancy, 0..DEPTH.
REQ-014 SHALL have ports wr_err and rd_err, each an output, 1 bit: one-cycle pulse for a rejected request.

Function
REQ-015 SHALL store data in an inferred simple-dual-port RAM of DEPTH x DATA_W, with ADDR_W-bit read and write pointers that wrap from DEPTH-1 to 0.
REQ-016 SHALL accept a write iff we=1 and full=0; an accepted write stores din at the write pointer and increments that pointer.
REQ-017 SHALL accept a read iff re=1 and empty=0.
REQ-018 SHALL, when re=1 and we=1 are both accepted in the same cycle, leave count unchanged and advance both pointers.
REQ-019 SHALL, for we=1 while full=1, drop the write and pulse wr_err for one cycle; this holds even when re=1 in the same cycle.
REQ-020 SHALL, for re=1 while empty=1, pulse rd_err for one cycle and leave dout and the pointers unchanged; this holds even when we=1 in the same cycle, and that write is still accepted.
REQ-021 SHALL update count on the edge after the request: +1 for an accepted write only, -1 for an accepted read only.
REQ-022 SHALL compute each flag from the next-state count, so the flags change on the same edge as count.
REQ-023 SHALL derive the flags as follows: empty = (count==0); full = (count==DEPTH); almost_full = (count >= DEPTH-AF_OFFSET); almost_empty = (count <= AE_OFFSET).
REQ-024 SHALL, when FWFT=0, present the popped word on dout on the edge after the accepted read (1-cycle read latency); dout holds its value otherwise.
REQ-025 SHALL, when FWFT=1, present the head word on dout whenever empty=0, with re acting as a pop.
REQ-026 SHALL, when FWFT=1 and the next word is not yet in the output register, advance dout to the next word on the edge after a pop, using a prefetch path.
REQ-027 SHALL, when FWFT=1, load a write into an empty FIFO directly into the output register, so that empty=0 and dout=din one cycle after the write edge.
REQ-028 SHALL, when FWFT=1, include the word held in the output register in count.
REQ-029 SHALL, when FWFT=1 and count==1, support a simultaneous pop and write: the written word appears on dout the next cycle and empty stays 0.
REQ-030 SHALL NOT corrupt stored data when a read and a write target the same RAM address in one cycle; the read returns the old contents or bypasses as required by REQ-027/REQ-029.

Reset
REQ-031 SHALL, on a clk edge with rst_n=0, set both pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, wr_err=0, rd_err=0 and dout=0.
REQ-032 SHALL NOT require RAM contents to be cleared by reset.
REQ-033 SHALL give reset priority over we and re; a reset asserted mid-stream discards all stored words.
REQ-034 SHALL accept a write on the first edge after rst_n returns to 1.

Verification
Unless stated otherwise, scenarios use DATA_W=32, ADDR_W=4 (DEPTH=16), AF_OFFSET=4, AE_OFFSET=4.
REQ-035 SHALL be verified by: FWFT=0, write 0x11,0x22,0x33, then re for 3 cycles -> dout=0x11,0x22,0x33 one cycle after each re; empty=1 after the 3rd pop; count sequence 1,2,3,2,1,0.
REQ-036 SHALL be verified by: write 16 words -> almost_full rises at count=12, full rises at count=16; a 17th write pulses wr_err, count stays 16, and the dropped word is never read back.
REQ-037 SHALL be verified by: re on an empty FIFO with we=1 and din=0xA5 -> rd_err pulses, count becomes 1, and the next read returns 0xA5.
REQ-038 SHALL be verified by: FWFT=1, write 0xDEAD into an empty FIFO -> next cycle empty=0 and dout=0xDEAD before any re; pop plus write of 0xBEEF at count=1 -> dout=0xBEEF and empty=0.
REQ-039 SHALL be verified by: fill to count=8 with pointers wrapped at least twice, then pull rst_n low for 1 cycle -> count=0, empty=1, dout=0; a subsequent write/read of 0x5A returns 0x5A.
REQ-040 SHALL be verified by: random we/re for 10,000 cycles against a queue model -> data order matches, count matches, and wr_err/rd_err fire only on rejected requests.
